pf_ddr4_ca_lane_ctrl: RTL and testbench

Parametrised DDR4 command/address output lane controller. It drives LANES single-ended IOD output lanes such as CAS_N, RAS_N, WE_N and ACT_N. It registers per-lane 4-phase TX/OE nibbles and substitutes an idle pattern when no command is valid. It also runs a per-lane TX delay-line sequencer that issues LOAD/MOVE/DIRECTION pulses and tracks each lane's tap position. It sits between the DDR4 PHY sequencer and the PF_IOD lane instances in the DDRPHY block.

---
 rtl/pf_ddr4_ca_lane_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pf_ddr4_ca_lane_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pf_ddr4_ca_lane_ctrl.sv
// DDR4 CA output lane controller: registered TX/OE nibbles plus a per-lane delay-line tap sequencer.
// Optional DDR4_CA_PARITY_EN builds per-phase even parity on PAR_DATA_O.
module pf_ddr4_ca_lane_ctrl #(
  parameter int                 LANES    = 8,
  parameter int                 DELAY_W  = 8,
  parameter int                 LOAD_TAP = 1,
  parameter int                 MAX_TAP  = 127,
  parameter int                 MOVE_GAP = 3,
  parameter logic [LANES-1:0]   IDLE_VAL = {LANES{1'b1}},
  localparam int                LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  input  logic                 TX_SYNC_RST,
  input  logic [4*LANES-1:0]   CMD_DATA,
  input  logic                 CMD_VALID,
  input  logic                 OE_REQ,
  output logic [4*LANES-1:0]   TX_DATA_O,
  output logic [4*LANES-1:0]   OE_DATA_O,
  output logic [3:0]           PAR_DATA_O,
  input  logic                 DLY_REQ,
  input  logic                 DLY_RELOAD,
  input  logic [LW-1:0]        DLY_LANE,
  input  logic [DELAY_W-1:0]   DLY_TARGET,
  output logic                 DLY_BUSY,
  output logic                 DLY_DONE,
  output logic                 DLY_ERR,
  output logic [DELAY_W-1:0]   DLY_CUR,
  output logic [LANES-1:0]     DELAY_LINE_LOAD_O,
  output logic [LANES-1:0]     DELAY_LINE_MOVE_O,
  output logic [LANES-1:0]     DELAY_LINE_DIRECTION_O,
  input  logic [LANES-1:0]     DELAY_LINE_OUT_OF_RANGE_I
);

  localparam int GW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_MOVE, S_GAP, S_DONE
  } state_t;

  logic [4*LANES-1:0] idle_pat;
  logic [4*LANES-1:0] tx_d, tx_q, oe_d, oe_q;

  state_t             state_d, state_q;
  logic [LW-1:0]      ln_d, ln_q;
  logic [DELAY_W-1:0] tgt_d, tgt_q;
  logic               err_d, err_q;
  logic               dir_d, dir_q;
  logic [GW-1:0]      gap_d, gap_q;
  logic [DELAY_W-1:0] taps_d [LANES];
  logic [DELAY_W-1:0] taps_q [LANES];
  logic [DELAY_W-1:0] cur_d, cur_q;
  logic [DELAY_W-1:0] tap_cur;
  logic               up;
  logic               set_dir;
  logic [LANES-1:0]   sel;

  // Idle nibble pattern: each lane's idle level on all four phases
  always_comb begin
    idle_pat = '0;
    for (int i = 0; i < LANES; i++)
      idle_pat[4*i +: 4] = {4{IDLE_VAL[i]}};
  end

  // Next TX/OE nibbles; sync reset forces idle and disables output
  always_comb begin
    tx_d = CMD_VALID ? CMD_DATA : idle_pat;
    oe_d = {4*LANES{OE_REQ}};
    if (TX_SYNC_RST) begin
      tx_d = idle_pat;
      oe_d = '0;
    end
  end

  // TX/OE output registers
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tx_q <= idle_pat;
      oe_q <= '0;
    end else begin
      tx_q <= tx_d;
      oe_q <= oe_d;
    end
  end

  assign TX_DATA_O = tx_q;
  assign OE_DATA_O = oe_q;

`ifdef DDR4_CA_PARITY_EN
  logic [3:0] par_d, par_q, par_idle;

  // Even parity per phase across all lanes, for live and idle data
  always_comb begin
    par_d    = '0;
    par_idle = '0;
    for (int i = 0; i < LANES; i++) begin
      par_d    = par_d ^ tx_d[4*i +: 4];
      par_idle = par_idle ^ idle_pat[4*i +: 4];
    end
  end

  // Parity register aligned with the TX register
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) par_q <= par_idle;
    else         par_q <= par_d;
  end

  assign PAR_DATA_O = par_q;
`else
  assign PAR_DATA_O = 4'b0000;
`endif

  assign tap_cur = taps_q[ln_q];
  assign up      = tgt_q > tap_cur;

  // Sequencer next state, tap bookkeeping and error flag
  always_comb begin
    state_d = state_q;
    ln_d    = ln_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    dir_d   = dir_q;
    gap_d   = gap_q;
    set_dir = 1'b0;
    for (int i = 0; i < LANES; i++) taps_d[i] = taps_q[i];
    unique case (state_q)
      S_IDLE: begin
        if (DLY_REQ) begin
          if (DLY_TARGET > DELAY_W'(MAX_TAP)) begin
            // Rejected target still spends one cycle so DONE timing is uniform
            err_d   = 1'b1;
            state_d = S_SETTLE;
          end else begin
            ln_d    = DLY_LANE;
            tgt_d   = DLY_TARGET;
            err_d   = 1'b0;
            state_d = DLY_RELOAD ? S_LOAD : S_SETTLE;
          end
        end
      end
      S_LOAD: begin
        taps_d[ln_q] = DELAY_W'(LOAD_TAP);
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        gap_d = '0;
        if (err_q || tap_cur == tgt_q) begin
          state_d = S_DONE;
        end else if ((up && tap_cur == '1) ||
                     (!up && tap_cur == '0)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dir_d   = up;
          set_dir = up;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        taps_d[ln_q] = dir_q ? tap_cur + 1'b1 : tap_cur - 1'b1;
        gap_d        = '0;
        state_d      = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(MOVE_GAP - 1)) begin
          if (DELAY_LINE_OUT_OF_RANGE_I[ln_q]) begin
            err_d        = 1'b1;
            taps_d[ln_q] = dir_q ? tap_cur - 1'b1 : tap_cur + 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cur_d = taps_q[DLY_LANE];

  // Sequencer state, latched request and per-lane tap registers
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= S_IDLE;
      ln_q    <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
      gap_q   <= '0;
      cur_q   <= DELAY_W'(LOAD_TAP);
      for (int i = 0; i < LANES; i++) taps_q[i] <= DELAY_W'(LOAD_TAP);
    end else begin
      state_q <= state_d;
      ln_q    <= ln_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
      gap_q   <= gap_d;
      cur_q   <= cur_d;
      for (int i = 0; i < LANES; i++) taps_q[i] <= taps_d[i];
    end
  end

  assign sel = LANES'(1) << ln_q;

  assign DLY_BUSY = state_q != S_IDLE;
  assign DLY_DONE = state_q == S_DONE;
  assign DLY_ERR  = err_q;
  assign DLY_CUR  = cur_q;

  assign DELAY_LINE_LOAD_O = (state_q == S_LOAD) ? sel : '0;
  assign DELAY_LINE_MOVE_O = (state_q == S_MOVE) ? sel : '0;
  assign DELAY_LINE_DIRECTION_O =
    (set_dir ||
     ((state_q == S_MOVE || state_q == S_GAP) && dir_q)) ? sel : '0;

endmodule

// File: tb/tb_pf_ddr4_ca_lane_ctrl.sv
// Directed bench for pf_ddr4_ca_lane_ctrl: datapath vector table
// plus hand-written delay sequencer scenarios.
module tb_pf_ddr4_ca_lane_ctrl;

  localparam int LANES = 8;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              tx_sync_rst;
  logic [4*LANES-1:0] cmd_data;
  logic              cmd_valid;
  logic              oe_req;
  logic [4*LANES-1:0] tx_data;
  logic [4*LANES-1:0] oe_data;
  logic [3:0]        par_data;
  logic              dly_req;
  logic              dly_reload;
  logic [2:0]        dly_lane;
  logic [DW-1:0]     dly_target;
  logic              dly_busy;
  logic              dly_done;
  logic              dly_err;
  logic [DW-1:0]     dly_cur;
  logic [LANES-1:0]  ld_o;
  logic [LANES-1:0]  mv_o;
  logic [LANES-1:0]  dir_o;
  logic [LANES-1:0]  oor_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pf_ddr4_ca_lane_ctrl dut (
    .FAB_CLK                   (clk),
    .ARST_N                    (arst_n),
    .TX_SYNC_RST               (tx_sync_rst),
    .CMD_DATA                  (cmd_data),
    .CMD_VALID                 (cmd_valid),
    .OE_REQ                    (oe_req),
    .TX_DATA_O                 (tx_data),
    .OE_DATA_O                 (oe_data),
    .PAR_DATA_O                (par_data),
    .DLY_REQ                   (dly_req),
    .DLY_RELOAD                (dly_reload),
    .DLY_LANE                  (dly_lane),
    .DLY_TARGET                (dly_target),
    .DLY_BUSY                  (dly_busy),
    .DLY_DONE                  (dly_done),
    .DLY_ERR                   (dly_err),
    .DLY_CUR                   (dly_cur),
    .DELAY_LINE_LOAD_O         (ld_o),
    .DELAY_LINE_MOVE_O         (mv_o),
    .DELAY_LINE_DIRECTION_O    (dir_o),
    .DELAY_LINE_OUT_OF_RANGE_I (oor_i)
  );

  typedef struct {
    logic        valid;
    logic        srst;
    logic        oe;
    logic [31:0] data;
    logic [31:0] exp_tx;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_par(input logic [31:0] v);
    logic [3:0] p;
    p = 4'b0000;
`ifdef DDR4_CA_PARITY_EN
    for (int i = 0; i < LANES; i++) p = p ^ v[4*i +: 4];
`endif
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one delay request and watch it to DONE
  task automatic run_seq(input string nm, input int lane, input int tgt,
                         input bit rl, input bit oor, input int exp_done,
                         input int exp_moves, input int exp_loads,
                         input bit exp_dir, input bit exp_e);
    int c, moves, loads, bad, last_mv, done_c;
    logic [7:0] sel;
    sel        = 8'(1) << lane;
    dly_lane   = 3'(lane);
    dly_target = 8'(tgt);
    dly_reload = rl;
    dly_req    = 1'b1;
    if (oor) oor_i = sel;
    tick();
    dly_req = 1'b0;
    c = 1; done_c = -1; moves = 0; loads = 0; bad = 0; last_mv = -1;
    chk({nm, " busy"}, 32'(dly_busy), 32'd1);
    while (c <= 300 && done_c < 0) begin
      if (mv_o != 0) begin
        moves++;
        if (mv_o != sel) bad++;
        if (dir_o != (exp_dir ? sel : 8'h00)) bad++;
        if (last_mv >= 0 && c - last_mv != 5) bad++;
        last_mv = c;
      end
      if (ld_o != 0) begin
        loads++;
        if (ld_o != sel) bad++;
      end
      if (dly_done) done_c = c;
      else begin
        tick();
        c++;
      end
    end
    chk({nm, " done_cycle"}, 32'(done_c), 32'(exp_done));
    chk({nm, " moves"}, 32'(moves), 32'(exp_moves));
    chk({nm, " loads"}, 32'(loads), 32'(exp_loads));
    chk({nm, " pulse_shape"}, 32'(bad), 32'd0);
    chk({nm, " err"}, 32'(dly_err), 32'(exp_e));
    tick();
    chk({nm, " busy_drop"}, 32'(dly_busy), 32'd0);
    oor_i = '0;
  endtask

  initial begin
    arst_n      = 1'b0;
    tx_sync_rst = 1'b0;
    cmd_data    = '0;
    cmd_valid   = 1'b0;
    oe_req      = 1'b0;
    dly_req     = 1'b0;
    dly_reload  = 1'b0;
    dly_lane    = '0;
    dly_target  = '0;
    oor_i       = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_00A5, 32'h0000_00A5, 32'hFFFF_FFFF};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst tx", tx_data, 32'hFFFF_FFFF);
    chk("rst oe", oe_data, 32'h0);
    chk("rst par", 32'(par_data), 32'(exp_par(32'hFFFF_FFFF)));
    chk("rst cur", 32'(dly_cur), 32'd1);
    chk("rst dly_out", {8'h0, ld_o, mv_o, dir_o}, 32'h0);
    chk("rst flags", {29'h0, dly_busy, dly_done, dly_err}, 32'h0);
    arst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cmd_valid   = vecs[i].valid;
      tx_sync_rst = vecs[i].srst;
      oe_req      = vecs[i].oe;
      cmd_data    = vecs[i].data;
      tick();
      chk($sformatf("vec%0d tx", i), tx_data, vecs[i].exp_tx);
      chk($sformatf("vec%0d oe", i), oe_data, vecs[i].exp_oe);
      chk($sformatf("vec%0d par", i), 32'(par_data),
          32'(exp_par(vecs[i].exp_tx)));
    end
    tx_sync_rst = 1'b0;

    // lane 3: 1 -> 4, three upward moves
    run_seq("up3", 3, 4, 1'b0, 1'b0, 17, 3, 0, 1'b1, 1'b0);
    chk("up3 cur", 32'(dly_cur), 32'd4);

    // reload to 1, then one move up to 2
    run_seq("reload", 3, 2, 1'b1, 1'b0, 8, 1, 1, 1'b1, 1'b0);
    chk("reload cur", 32'(dly_cur), 32'd2);

    // lane 3: 2 -> 1 without reload, one downward move
    run_seq("down1", 3, 1, 1'b0, 1'b0, 7, 1, 0, 1'b0, 1'b0);
    chk("down1 cur", 32'(dly_cur), 32'd1);

    // back up to 2 for the following cases
    run_seq("up1", 3, 2, 1'b0, 1'b0, 7, 1, 0, 1'b1, 1'b0);

    run_seq("badtgt", 3, 200, 1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b1);
    chk("badtgt cur", 32'(dly_cur), 32'd2);

    run_seq("oor", 3, 5, 1'b0, 1'b1, 6, 1, 0, 1'b1, 1'b1);
    tick();
    chk("oor cur", 32'(dly_cur), 32'd2);

    // zero-distance request clears the sticky error
    run_seq("noop", 5, 1, 1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b0);
    chk("noop cur", 32'(dly_cur), 32'd1);

    // async reset in the middle of GAP
    dly_lane   = 3'd0;
    dly_target = 8'd3;
    dly_reload = 1'b0;
    dly_req    = 1'b1;
    tick();
    dly_req = 1'b0;
    tick();
    tick();
    chk("midgap dir", 32'(dir_o), 32'h01);
    arst_n = 1'b0;
    #1;
    chk("arst busy", 32'(dly_busy), 32'd0);
    chk("arst dly_out", {8'h0, ld_o, mv_o, dir_o}, 32'h0);
    chk("arst cur", 32'(dly_cur), 32'd1);
    chk("arst tx", tx_data, 32'hFFFF_FFFF);
    chk("arst oe", oe_data, 32'h0);
    #2;
    arst_n   = 1'b1;
    dly_lane = 3'd3;
    tick();
    tick();
    chk("arst lane3 tap", 32'(dly_cur), 32'd1);

    run_seq("post", 0, 2, 1'b0, 1'b0, 7, 1, 0, 1'b1, 1'b0);
    chk("post cur", 32'(dly_cur), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
